multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Execution-stage ALU that consumes the `ALUType::alu_cmd_t` commands produced by the ALU controller and returns results over a valid/ready handshake. Logic, arithmetic and compare commands complete in one cycle. SLL/SRL are performed by a serial one-bit-per-cycle shifter unless the barrel shifter is compiled in. It sits between the register-file read stage and write-back of the multi-cycle datapath.

## Interface
- `WIDTH`, 32, operand/result width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  command/operands valid
- `in_ready`  out  1  block accepts a command this cycle
- `cmd`  in  `ALUType::alu_cmd_t`  operation: ADD, SUB, AND, OR, SLL, SRL, LESS_THAN, EQUAL, NONE
- `a`  in  WIDTH  operand A (rs)
- `b`  in  WIDTH  operand B (rt or sign-extended immediate); shift source for SLL/SRL
- `shamt`  in  5  shift amount for SLL/SRL; ignored otherwise
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result
- `result`  out  WIDTH  operation result
- `zero`  out  1  `result == 0`

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `zero`=1, internal shift counter 0.
- `in_ready` = 1 only in IDLE. A command is accepted on a cycle with `in_valid && in_ready`. `cmd`, `a`, `b` and `shamt` are captured on acceptance and must not be sampled afterwards.
- Operations on acceptance in IDLE (result registered, state → DONE):
  - ADD/SUB: `a ± b` mod 2^WIDTH; overflow ignored.
  - AND/OR: bitwise.
  - LESS_THAN: signed compare, result `{0…,a<b}`.
  - EQUAL: result `{0…,a==b}`.
  - NONE: result 0.
- Serial shifts, SLL/SRL, in IDLE:
  - `shamt==0`: result = b, state → DONE.
  - Otherwise: load b into the working register, counter = shamt, state → SHIFT.
- SHIFT: each cycle, shift the working register by 1 (SLL left, SRL logical right, zero fill) and decrement the counter. When the counter would reach 0, write the final value to `result` and move to DONE.
- DONE: `out_valid`=1. `result`/`zero` are held stable until `out_ready`=1. On `out_valid && out_ready`, move to IDLE.
- A new command cannot be accepted in the same cycle as a result handoff. `in_ready` rises the cycle after the handoff.
- `zero` is always derived from the registered `result`.

## Timing
- Command accepted at edge N (non-shift, or shift with shamt=0): `out_valid` high from cycle N+1.
- Serial shift with shamt=k (k≥1): `out_valid` high from cycle N+1+k.
- Result held indefinitely under backpressure (`out_ready`=0). No loss, no change.
- Peak throughput: one command per 2 cycles.
- `rst` asserted in any state, including mid-SHIFT or DONE with a pending result: the next cycle is IDLE with the reset values. The in-flight operation is discarded and no `out_valid` pulse is produced.
- `rst` has priority over both handshakes in the same cycle.
- `in_valid` while `in_ready`=0: ignored. The producer must hold the command.

## Configuration
- `MULTICYCLE_ALU_BARREL_SHIFT_EN` defined: SLL/SRL complete combinationally in IDLE like every other op. The SHIFT state and counter are not built, and all commands have 1-cycle latency.
- Undefined: serial shifter as described above, for smaller area.

## Test plan
- Reset, then ADD a=0x7FFF_FFFF, b=1 → one cycle later `out_valid`=1, result=0x8000_0000, zero=0. SUB a=5, b=5 → result=0, zero=1.
- LESS_THAN a=0xFFFF_FFFF (−1), b=1 → result=1. EQUAL a=b=0x1234 → result=1. NONE → result=0, `out_valid` still pulses.
- SLL b=0x1, shamt=31 (serial build) → `out_valid` exactly 32 cycles after acceptance, result=0x8000_0000. SRL b=0x8000_0000, shamt=4 → result=0x0800_0000 after 5 cycles. shamt=0 → result=b after 1 cycle. With the macro defined → all after 1 cycle.
- Backpressure: hold `out_ready`=0 for 10 cycles after OR a=0xF0, b=0x0F → result=0xFF stable, `in_ready`=0 throughout. Release → handoff, `in_ready`=1 next cycle.
- Assert `rst` in the 3rd cycle of SLL shamt=8 → the next cycle shows IDLE reset values, and no `out_valid` ever appears for the aborted command.
- Back-to-back random commands with random `in_valid`/`out_ready` against a scoreboard model → results match in order, none dropped or duplicated.

Source files
------------

// File: rtl/multicycle_alu.sv
// multicycle_alu: execution-stage ALU with a valid/ready handshake on both sides.
// Logic, arithmetic and compare commands take one cycle. SLL/SRL use a serial
// one-bit-per-cycle shifter unless MULTICYCLE_ALU_BARREL_SHIFT_EN is defined,
// in which case shifts also complete in one cycle and the SHIFT path is not built.
//
// state | meaning
// IDLE  | ready for a command (in_ready=1)
// SHIFT | serial shift in progress, one bit per cycle
// DONE  | result valid, held until out_ready

package ALUType;
   typedef enum logic [3:0] {
      NONE      = 4'd0,
      ADD       = 4'd1,
      SUB       = 4'd2,
      AND       = 4'd3,
      OR        = 4'd4,
      SLL       = 4'd5,
      SRL       = 4'd6,
      LESS_THAN = 4'd7,
      EQUAL     = 4'd8
   } alu_cmd_t;
endpackage

module multicycle_alu #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  ALUType::alu_cmd_t  cmd,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [4:0]         shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t state;

`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
   logic [WIDTH-1:0] work;
   logic [4:0]       cnt;
   logic             shift_left;
   logic [WIDTH-1:0] work_next;

   // One-bit step of the serial shifter, zero fill on both directions
   always_comb begin
      work_next = shift_left ? {work[WIDTH-2:0], 1'b0} : {1'b0, work[WIDTH-1:1]};
   end
`endif

   // Handshake flags come straight from the state register
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign zero      = (result == '0);

   // Main FSM: accept in IDLE, iterate in SHIFT, hold result in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         result <= '0;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
         work       <= '0;
         cnt        <= '0;
         shift_left <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= DONE;
                  case (cmd)
                     ALUType::ADD:       result <= a + b;
                     ALUType::SUB:       result <= a - b;
                     ALUType::AND:       result <= a & b;
                     ALUType::OR:        result <= a | b;
                     ALUType::LESS_THAN: result <= {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                     ALUType::EQUAL:     result <= {{(WIDTH-1){1'b0}}, (a == b)};
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
                     ALUType::SLL:       result <= b << shamt;
                     ALUType::SRL:       result <= b >> shamt;
`else
                     ALUType::SLL, ALUType::SRL: begin
                        if (shamt == 5'd0) begin
                           result <= b;
                        end else begin
                           work       <= b;
                           cnt        <= shamt;
                           shift_left <= (cmd == ALUType::SLL);
                           state      <= SHIFT;
                        end
                     end
`endif
                     default:            result <= '0;
                  endcase
               end
            end
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
            SHIFT: begin
               work <= work_next;
               cnt  <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  result <= work_next;
                  state  <= DONE;
               end
            end
`endif
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and scoreboard-checked bench for multicycle_alu.
module tb_multicycle_alu;
   import ALUType::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   alu_cmd_t    cmd;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   int checks   = 0;
   int failures = 0;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
   localparam bit SERIAL = 1'b0;
`else
   localparam bit SERIAL = 1'b1;
`endif

   multicycle_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cmd       (cmd),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input alu_cmd_t c, input logic [31:0] x,
                                           input logic [31:0] y, input logic [4:0] s);
      case (c)
         ADD:       return x + y;
         SUB:       return x - y;
         AND:       return x & y;
         OR:        return x | y;
         SLL:       return y << s;
         SRL:       return y >> s;
         LESS_THAN: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         EQUAL:     return (x == y) ? 32'd1 : 32'd0;
         default:   return 32'd0;
      endcase
   endfunction

   // Issue one command from IDLE, measure latency, check result and handoff.
   task automatic run_op(input string tag, input alu_cmd_t c, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh,
                         input logic [31:0] exp_r, input int exp_lat);
      int lat;
      cmd = c; a = av; b = bv; shamt = sh; in_valid = 1'b1;
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h5A5A_A5A5; shamt = 5'd17; cmd = SUB;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_r == 32'd0)});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] exp_q[$];
      logic        pending;
      logic        acc;
      logic        hs;
      logic        seen;
      int          n_out;
      int          n_in;
      int          guard;
      alu_cmd_t    rc;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [4:0]  rs;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cmd = NONE; a = '0; b = '0; shamt = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_zero", {31'd0, zero}, 32'd1);
      rst = 1'b0;

      run_op("add_ovf", ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1);
      run_op("sub_zero", SUB, 32'd5, 32'd5, 5'd0, 32'h0, 1);
      run_op("lt_neg", LESS_THAN, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1);
      run_op("lt_false", LESS_THAN, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1);
      run_op("eq_true", EQUAL, 32'h1234, 32'h1234, 5'd0, 32'h1, 1);
      run_op("and", AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234, 1);
      run_op("none", NONE, 32'h1234, 32'h5678, 5'd0, 32'h0, 1);
      run_op("sll31", SLL, 32'h0, 32'h1, 5'd31, 32'h8000_0000, SERIAL ? 32 : 1);
      run_op("srl4", SRL, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, SERIAL ? 5 : 1);
      run_op("sll0", SLL, 32'h0, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 1);
      run_op("srl1", SRL, 32'h0, 32'h0000_0003, 5'd1, 32'h0000_0001, SERIAL ? 2 : 1);

      // Backpressure: hold out_ready low for 10 cycles
      cmd = OR; a = 32'hF0; b = 32'h0F; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 32'h0; b = 32'h0;
      seen = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (result !== 32'hFF || in_ready !== 1'b0 || out_valid !== 1'b1) seen = 1'b0;
         @(posedge clk); #1;
      end
      check("bp_hold_stable", {31'd0, seen}, 32'd1);
      check("bp_result", result, 32'hFF);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);

      // Reset in the 3rd cycle of a serial SLL by 8
      cmd = SLL; b = 32'h1; shamt = 5'd8; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_zero", {31'd0, zero}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("abort_no_out_valid", {31'd0, seen}, 32'd0);

      // Random back-to-back traffic against a scoreboard
      pending = 1'b0; n_out = 0; n_in = 0;
      rc = NONE; ra = '0; rb = '0; rs = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (!pending && $urandom_range(0, 2) != 0) begin
            rc = alu_cmd_t'($urandom_range(0, 8));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rs = 5'($urandom_range(0, 31));
            pending = 1'b1;
         end
         in_valid = pending; cmd = rc; a = ra; b = rb; shamt = rs;
         out_ready = 1'($urandom_range(0, 1));
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         if (hs) begin
            if (exp_q.size() == 0) begin
               check("rand_spurious_out", 32'd1, 32'd0);
            end else begin
               check($sformatf("rand_result_%0d", n_out), result, exp_q.pop_front());
               n_out++;
            end
         end
         if (acc) begin
            exp_q.push_back(ref_alu(rc, ra, rb, rs));
            n_in++;
            pending = 1'b0;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         if (out_valid) begin
            check($sformatf("drain_result_%0d", n_out), result, exp_q.pop_front());
            n_out++;
         end
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      check("rand_count", n_out, n_in);
      check("rand_queue_empty", exp_q.size(), 32'd0);
      check("rand_final_out_valid", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
